timed_traffic_controller: RTL and testbench

Parametrised two-road intersection controller that replaces the fixed-timing light system and its divided clock. A tick generator produces a single-cycle enable every `DIV` clocks, so the whole design runs on the one system clock. The FSM adds configurable minimum and maximum green, yellow and all-red clearance times, and a night flashing-yellow mode. It sits directly under the board top, driving the two road lamp triplets from the car sensors and a night switch.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/tick_gen.sv | 28 ++
 rtl/timed_traffic_controller.sv | 107 ++++++++++
 tb/tb_timed_traffic_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-road timed traffic controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED_BA   = 3'd5,
        FLASH    = 3'd6
    } state_t;

    // Lamp triplets are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// One-cycle enable pulse every DIV clocks; the design stays on a single clock.
module tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // DIV=1 still gets a 1-bit counter that never leaves 0, so tick is constant high.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timed_traffic_controller.sv
// Two-road intersection FSM with min/max green, yellow, all-red clearance and
// a night flashing-yellow mode, all advanced by a divided-down tick enable.
module timed_traffic_controller
    import traffic_pkg::*;
#(
    parameter int DIV          = 50_000_000,
    parameter int GREEN_MIN    = 5,
    parameter int MAX_GREEN    = 15,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa,
    input  logic       sb,
    input  logic       night,
    output logic [2:0] La,
    output logic [2:0] Lb,
    output logic [2:0] phase
);

    localparam int TW = $clog2(MAX_GREEN + 1);
    localparam logic [TW-1:0] GMIN_L = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_L = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_L  = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] AR_L   = TW'(ALLRED_TICKS - 1);

    logic          tick;
    state_t        state_q, state_d, nxt;
    logic [TW-1:0] timer_q, timer_d;
    logic          blink_q, blink_d;
    logic          exit_now;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        blink_d  = blink_q;
        nxt      = state_q;
        exit_now = 1'b0;
        case (state_q)
            A_GREEN:  if (timer_q >= GMIN_L && (!sa || timer_q >= GMAX_L)) begin
                          exit_now = 1'b1; nxt = A_YELLOW;
                      end
            A_YELLOW: if (timer_q == YEL_L) begin exit_now = 1'b1; nxt = RED_AB; end
            RED_AB:   if (timer_q == AR_L)  begin exit_now = 1'b1; nxt = B_GREEN; end
            B_GREEN:  if (timer_q >= GMIN_L && (!sb || timer_q >= GMAX_L)) begin
                          exit_now = 1'b1; nxt = B_YELLOW;
                      end
            B_YELLOW: if (timer_q == YEL_L) begin exit_now = 1'b1; nxt = RED_BA; end
            RED_BA:   if (timer_q == AR_L)  begin exit_now = 1'b1; nxt = A_GREEN; end
            FLASH:    if (!night)           begin exit_now = 1'b1; nxt = RED_BA; end
            default:  begin exit_now = 1'b1; nxt = A_GREEN; end
        endcase
        // Night request overrides any pending exit from a normal state.
        if (night && state_q != FLASH) begin
            exit_now = 1'b1;
            nxt      = FLASH;
        end
        if (tick) begin
            if (exit_now) begin
                state_d = nxt;
                timer_d = '0;
                blink_d = 1'b0;
            end else begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (state_q == FLASH) blink_d = ~blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= A_GREEN;
            timer_q <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        La = RED;
        Lb = RED;
        case (state_q)
            A_GREEN:  La = GRN;
            A_YELLOW: La = YEL;
            B_GREEN:  Lb = GRN;
            B_YELLOW: Lb = YEL;
            FLASH: begin
                La = blink_q ? YEL : OFF;
                Lb = blink_q ? YEL : OFF;
            end
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_timed_traffic_controller.sv
// Directed bench: vector tables for per-tick sequences, hand sequences for reset and tick timing.
module tb_timed_traffic_controller;

    localparam int DIVT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sa, sb, night;
    logic [2:0] La, Lb, phase;
    logic       z = 1'b0;
    logic [2:0] la1, lb1, ph1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       sa;
        logic       sb;
        logic       night;
        int         nticks;
        logic [2:0] la;
        logic [2:0] lb;
        logic [2:0] ph;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    timed_traffic_controller #(
        .DIV(DIVT), .GREEN_MIN(3), .MAX_GREEN(6), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
    ) dut (
        .clk(clk), .reset(reset), .sa(sa), .sb(sb), .night(night),
        .La(La), .Lb(Lb), .phase(phase)
    );

    timed_traffic_controller #(
        .DIV(1), .GREEN_MIN(3), .MAX_GREEN(6), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
    ) d1 (
        .clk(clk), .reset(reset), .sa(z), .sb(z), .night(z),
        .La(la1), .Lb(lb1), .phase(ph1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n * DIVT) step();
    endtask

    task automatic do_reset();
        sa = 0; sb = 0; night = 0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic add(input logic a, input logic b, input logic n, input int t,
                       input logic [2:0] la, input logic [2:0] lb, input logic [2:0] ph);
        vec_t v;
        v.sa = a; v.sb = b; v.night = n; v.nticks = t;
        v.la = la; v.lb = lb; v.ph = ph;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            sa = tbl[i].sa; sb = tbl[i].sb; night = tbl[i].night;
            tick_n(tbl[i].nticks);
            check($sformatf("%s[%0d].La", tag, i), int'(La), int'(tbl[i].la));
            check($sformatf("%s[%0d].Lb", tag, i), int'(Lb), int'(tbl[i].lb));
            check($sformatf("%s[%0d].phase", tag, i), int'(phase), int'(tbl[i].ph));
        end
        tbl.delete();
    endtask

    initial begin
        sa = 0; sb = 0; night = 0; reset = 1'b1;
        step();

        // Reset: lamps right after release, tick at cycles 3/7/11, DIV=1 A green lasts 3 cycles
        do_reset();
        check("rst.La", int'(La), 3'b001);
        check("rst.Lb", int'(Lb), 3'b100);
        check("rst.phase", int'(phase), 0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("rst.tick@%0d", k), int'(dut.tick), (k % 4 == 3) ? 1 : 0);
            if (k < 4) check($sformatf("div1.phase@%0d", k), int'(ph1), (k < 3) ? 0 : 1);
            step();
        end

        // No cars: one full A->B->A cycle, one tick per vector
        do_reset();
        add(0,0,0,1, 3'b001,3'b100,0); add(0,0,0,1, 3'b001,3'b100,0);
        add(0,0,0,1, 3'b010,3'b100,1); add(0,0,0,1, 3'b010,3'b100,1);
        add(0,0,0,1, 3'b100,3'b100,2); add(0,0,0,1, 3'b100,3'b001,3);
        add(0,0,0,1, 3'b100,3'b001,3); add(0,0,0,1, 3'b100,3'b001,3);
        add(0,0,0,1, 3'b100,3'b010,4); add(0,0,0,1, 3'b100,3'b010,4);
        add(0,0,0,1, 3'b100,3'b100,5); add(0,0,0,1, 3'b001,3'b100,0);
        run_tbl("nocar");

        // Road A busy: green capped at 6 ticks
        do_reset();
        add(1,0,0,5, 3'b001,3'b100,0); add(1,0,0,1, 3'b010,3'b100,1);
        run_tbl("abusy");

        // sa dropped at tick 4 ends green there; then B busy runs to its max
        do_reset();
        add(1,0,0,3, 3'b001,3'b100,0); add(0,0,0,1, 3'b010,3'b100,1);
        add(0,0,0,2, 3'b100,3'b100,2); add(0,1,0,1, 3'b100,3'b001,3);
        add(0,1,0,5, 3'b100,3'b001,3); add(0,1,0,1, 3'b100,3'b010,4);
        run_tbl("adrop");

        // Night raised during B green, then dropped
        do_reset();
        add(0,0,0,7, 3'b100,3'b001,3);
        add(0,0,1,1, 3'b000,3'b000,6); add(0,0,1,1, 3'b010,3'b010,6);
        add(0,0,1,1, 3'b000,3'b000,6); add(0,0,1,1, 3'b010,3'b010,6);
        add(0,0,0,1, 3'b100,3'b100,5); add(0,0,0,1, 3'b001,3'b100,0);
        run_tbl("night");

        // Night on the same tick a green would exit: FLASH wins
        do_reset();
        add(0,0,0,2, 3'b001,3'b100,0); add(0,0,1,1, 3'b000,3'b000,6);
        run_tbl("nprio");

        // Sensor pulse between ticks is ignored
        do_reset();
        sa = 1'b1;
        tick_n(2);
        sa = 1'b0; step(); sa = 1'b1;
        repeat (DIVT - 1) step();
        check("glitch.phase", int'(phase), 0);

        // Reset mid B_YELLOW, then next tick 4 cycles after release
        do_reset();
        tick_n(9);
        check("midrst.pre", int'(phase), 4);
        step();
        reset = 1'b1;
        step();
        check("midrst.La", int'(La), 3'b001);
        check("midrst.Lb", int'(Lb), 3'b100);
        check("midrst.phase", int'(phase), 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midrst.tick@%0d", k), int'(dut.tick), (k == 3) ? 1 : 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
